// File: rtl/sha1_msg_sched_if.sv
// Padded-message word stream from sha1_msg_sched to the SHA-1 compression datapath.
// Master drives data/valid/idx/last; slave drives ready; transfer when w_valid & w_ready.
interface sha1_msg_sched_if;
  logic [31:0] w_data;
  logic        w_valid;
  logic        w_ready;
  logic [3:0]  w_idx;
  logic        w_last;

  modport master (
    output w_data,
    output w_valid,
    output w_idx,
    output w_last,
    input  w_ready
  );

  modport slave (
    input  w_data,
    input  w_valid,
    input  w_idx,
    input  w_last,
    output w_ready
  );
endinterface

// File: rtl/sha1_msg_sched.sv
// SHA-1 message scheduler: reads a message from dpsram port A, pads it, streams 16 words/block.
// Optional build macro SHA1_SCHED_LE_SRAM_EN: dpsram words are little-endian, byte-swapped on capture.
module sha1_msg_sched #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              nreset,
  input  logic              start,
  input  logic [31:0]       message_addr,
  input  logic [31:0]       message_size,
  output logic              port_A_clk,
  output logic [ADDR_W-1:0] port_A_addr,
  output logic              port_A_we,
  output logic [31:0]       port_A_data_in,
  input  logic [31:0]       port_A_data_out,
  sha1_msg_sched_if.master  w,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_GEN,
    S_PRESENT,
    S_DONE
  } state_t;

  state_t      state;
  logic [31:0] addr_q;
  logic [31:0] size_q;
  logic [31:0] g;
  logic [1:0]  lat_cnt;

  logic [31:0] g_nx;
  logic [27:0] nblk_m1;
  logic [31:0] last_g;
  logic        final_blk;
  logic        is_final;
  logic        fetch_nx;
  logic [31:0] mem_word;
  logic [31:0] src_word;
  logic [31:0] word;
  logic [33:0] bidx;

  assign port_A_clk     = clk;
  assign port_A_we      = 1'b0;
  assign port_A_data_in = '0;

`ifdef SHA1_SCHED_LE_SRAM_EN
  assign mem_word = {port_A_data_out[7:0], port_A_data_out[15:8],
                     port_A_data_out[23:16], port_A_data_out[31:24]};
`else
  assign mem_word = port_A_data_out;
`endif

  // Block count minus one fits 27 bits for any 32-bit size, so the last word index fits 32.
  assign nblk_m1   = 28'(({1'b0, size_q} + 33'd8) >> 6);
  assign last_g    = {nblk_m1, 4'hF};
  assign g_nx      = g + 32'd1;
  assign final_blk = (g[31:4] == nblk_m1);
  assign is_final  = (g == last_g);
  assign fetch_nx  = ({g_nx, 2'b00} < {2'b00, size_q});
  assign src_word  = (state == S_FETCH) ? mem_word : '0;

  always_comb begin
    word = '0;
    bidx = '0;
    for (int unsigned k = 0; k < 4; k++) begin
      bidx = {g, 2'b00} + 34'(k);
      if (bidx < {2'b00, size_q}) begin
        word[8*(3-k) +: 8] = src_word[8*(3-k) +: 8];
      end else if (bidx == {2'b00, size_q}) begin
        word[8*(3-k) +: 8] = 8'h80;
      end
    end
    // Padding always leaves room for the length, so these words never carry message bytes.
    if (final_blk && (g[3:0] == 4'd14)) begin
      word = {29'b0, size_q[31:29]};
    end else if (final_blk && (g[3:0] == 4'd15)) begin
      word = {size_q[28:0], 3'b000};
    end
  end

  always_ff @(posedge clk) begin
    if (!nreset) begin
      state       <= S_IDLE;
      addr_q      <= '0;
      size_q      <= '0;
      g           <= '0;
      lat_cnt     <= '0;
      port_A_addr <= '0;
      w.w_data    <= '0;
      w.w_valid   <= 1'b0;
      w.w_idx     <= '0;
      w.w_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            addr_q  <= message_addr;
            size_q  <= message_size;
            g       <= '0;
            lat_cnt <= '0;
            busy    <= 1'b1;
            if (message_size != 32'd0) begin
              port_A_addr <= message_addr[ADDR_W-1:0];
              state       <= S_FETCH;
            end else begin
              state <= S_GEN;
            end
          end
        end

        S_FETCH: begin
          if (lat_cnt == 2'(RD_LAT)) begin
            w.w_data  <= word;
            w.w_idx   <= g[3:0];
            w.w_last  <= is_final;
            w.w_valid <= 1'b1;
            state     <= S_PRESENT;
          end else begin
            lat_cnt <= lat_cnt + 2'd1;
          end
        end

        S_GEN: begin
          w.w_data  <= word;
          w.w_idx   <= g[3:0];
          w.w_last  <= is_final;
          w.w_valid <= 1'b1;
          state     <= S_PRESENT;
        end

        S_PRESENT: begin
          if (w.w_ready) begin
            w.w_valid <= 1'b0;
            w.w_last  <= 1'b0;
            if (is_final) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= S_DONE;
            end else begin
              g       <= g_nx;
              lat_cnt <= '0;
              if (fetch_nx) begin
                port_A_addr <= ADDR_W'(addr_q + g_nx);
                state       <= S_FETCH;
              end else begin
                state <= S_GEN;
              end
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sha1_msg_sched.sv
// Scoreboard bench for sha1_msg_sched: a byte-level padding model feeds an expectation queue
// that a negedge monitor drains on every accepted word.
module tb_sha1_msg_sched;

  logic        clk = 1'b0;
  logic        nreset = 1'b0;
  logic        start = 1'b0;
  logic [31:0] message_addr = '0;
  logic [31:0] message_size = '0;
  logic        port_A_clk;
  logic [15:0] port_A_addr;
  logic        port_A_we;
  logic [31:0] port_A_data_in;
  logic [31:0] port_A_data_out;
  logic        busy;
  logic        done;

  sha1_msg_sched_if w();

  sha1_msg_sched #(.ADDR_W(16), .RD_LAT(1)) dut (
    .clk             (clk),
    .nreset          (nreset),
    .start           (start),
    .message_addr    (message_addr),
    .message_size    (message_size),
    .port_A_clk      (port_A_clk),
    .port_A_addr     (port_A_addr),
    .port_A_we       (port_A_we),
    .port_A_data_in  (port_A_data_in),
    .port_A_data_out (port_A_data_out),
    .w               (w),
    .busy            (busy),
    .done            (done)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [0:65535];
  always @(posedge port_A_clk) port_A_data_out <= mem[port_A_addr];

  typedef struct {
    logic [31:0] data;
    logic [3:0]  idx;
    logic        last;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] got[$];
  logic [7:0]  msg_q[$];
  int          checks = 0;
  int          failures = 0;
  int          done_cnt = 0;
  int          addr_chg = 0;
  logic        rnd_ready = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%08h required=0x%08h", name, act, req);
    end
  endtask

  task automatic fail_now(input string name, input string what);
    checks++;
    failures++;
    $display("FAIL %s %s", name, what);
  endtask

  // Message bytes plus the memory image; bytes past the end of the message are filled
  // with 'fill' so the DUT's masking is exercised.
  task automatic load_msg(input logic [31:0] addr, input int size, input int seed,
                          input logic [7:0] fill);
    logic [7:0]  b [4];
    logic [31:0] wd;
    msg_q.delete();
    for (int i = 0; i < size; i++) msg_q.push_back(8'(seed + i * 13 + (i >> 3)));
    for (int n = 0; 4 * n < size; n++) begin
      for (int k = 0; k < 4; k++) b[k] = (4 * n + k < size) ? msg_q[4 * n + k] : fill;
`ifdef SHA1_SCHED_LE_SRAM_EN
      wd = {b[3], b[2], b[1], b[0]};
`else
      wd = {b[0], b[1], b[2], b[3]};
`endif
      mem[16'(addr + 32'(n))] = wd;
    end
  endtask

  task automatic build_expect(input int size);
    int          nb;
    int          total;
    longint      len;
    logic [7:0]  bt;
    logic [31:0] wd;
    exp_t        e;
    nb    = ((size + 8) / 64) + 1;
    total = 64 * nb;
    len   = longint'(size) * 8;
    for (int n = 0; n < 16 * nb; n++) begin
      wd = '0;
      for (int k = 0; k < 4; k++) begin
        int i;
        i = 4 * n + k;
        if (i >= total - 8) bt = 8'(len >> (8 * (7 - (i - (total - 8)))));
        else if (i < size)  bt = msg_q[i];
        else if (i == size) bt = 8'h80;
        else                bt = 8'h00;
        wd = {wd[23:0], bt};
      end
      e.data = wd;
      e.idx  = 4'(n % 16);
      e.last = (n == 16 * nb - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic start_msg(input logic [31:0] addr, input int size, input logic rnd);
    got.delete();
    rnd_ready = rnd;
    @(posedge clk); #1;
    message_addr = addr;
    message_size = 32'(size);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    chk("busy_after_start", {31'b0, busy}, 32'd1);
  endtask

  task automatic wait_done(input int d0, input string name);
    int n;
    n = 0;
    while (done_cnt == d0 && n < 4000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (done_cnt == d0) fail_now(name, "timeout waiting for done");
    chk({name, "_drained"}, 32'(exp_q.size()), 32'd0);
    chk({name, "_busy_end"}, {31'b0, busy}, 32'd0);
  endtask

  task automatic run(input logic [31:0] addr, input int size, input logic rnd,
                     input int reads, input logic [7:0] fill, input string name);
    int d0;
    int a0;
    load_msg(addr, size, size + 3, fill);
    build_expect(size);
    d0 = done_cnt;
    a0 = addr_chg;
    start_msg(addr, size, rnd);
    wait_done(d0, name);
    chk({name, "_reads"}, 32'(addr_chg - a0), 32'(reads));
  endtask

  initial begin
    w.w_ready = 1'b0;
    forever begin
      @(posedge clk); #1;
      w.w_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: pops one expectation per accepted word and tracks stall, done and read activity.
  initial begin
    logic        stalled;
    logic        exp_done;
    logic        done_seen;
    logic [31:0] st_data;
    logic [3:0]  st_idx;
    logic [15:0] prev_a;
    exp_t        e;
    stalled = 0; exp_done = 0; done_seen = 0; st_data = '0; st_idx = '0; prev_a = '0;
    forever begin
      @(negedge clk);
      if (!nreset) begin
        stalled = 0; exp_done = 0; done_seen = 0;
        prev_a = port_A_addr;
      end else begin
        if (done_seen) begin
          chk("done_width", {31'b0, done}, 32'd0);
          done_seen = 0;
        end
        if (exp_done) begin
          chk("done_pulse", {31'b0, done}, 32'd1);
          exp_done = 0;
          if (done === 1'b1) begin done_cnt++; done_seen = 1; end
        end else if (done === 1'b1) begin
          fail_now("done_spurious", "done=1 required=0");
          done_cnt++;
          done_seen = 1;
        end
        if (stalled) begin
          if (w.w_valid !== 1'b1) fail_now("valid_drop", "w_valid=0 while stalled, required=1");
          else begin
            chk("stall_data", w.w_data, st_data);
            chk("stall_idx", {28'b0, w.w_idx}, {28'b0, st_idx});
          end
        end
        stalled = 0;
        if (w.w_valid === 1'b1) begin
          if (w.w_ready) begin
            if (exp_q.size() == 0) begin
              fail_now("unexpected_word", $sformatf("w_data=0x%08h with no expectation", w.w_data));
            end else begin
              e = exp_q.pop_front();
              chk("w_data", w.w_data, e.data);
              chk("w_idx", {28'b0, w.w_idx}, {28'b0, e.idx});
              chk("w_last", {31'b0, w.w_last}, {31'b0, e.last});
              exp_done = e.last;
            end
            got.push_back(w.w_data);
          end else begin
            stalled = 1;
            st_data = w.w_data;
            st_idx  = w.w_idx;
          end
        end
        if (port_A_addr !== prev_a) begin
          addr_chg++;
          prev_a = port_A_addr;
        end
      end
    end
  end

  initial begin
    int d0;
    int n;
    nreset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_w_valid", {31'b0, w.w_valid}, 32'd0);
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_done", {31'b0, done}, 32'd0);
    chk("rst_w_last", {31'b0, w.w_last}, 32'd0);
    chk("rst_w_idx", {28'b0, w.w_idx}, 32'd0);
    chk("rst_addr", {16'b0, port_A_addr}, 32'd0);
    chk("port_we", {31'b0, port_A_we}, 32'd0);
    chk("port_din", port_A_data_in, 32'd0);
    nreset = 1'b1;

    // Empty message: one block, entirely generated.
    run(32'h0000_0100, 0, 1'b0, 0, 8'hEE, "t1");
    chk("t1_count", 32'(got.size()), 32'd16);
    if (got.size() == 16) begin
      chk("t1_w0", got[0], 32'h8000_0000);
      chk("t1_w15", got[15], 32'h0000_0000);
    end

    // "abc"
    msg_q.delete();
    build_expect(0);
    exp_q.delete();
    msg_q = '{8'h61, 8'h62, 8'h63};
`ifdef SHA1_SCHED_LE_SRAM_EN
    mem[16'h0020] = 32'h0063_6261;
`else
    mem[16'h0020] = 32'h6162_6300;
`endif
    build_expect(3);
    d0 = done_cnt;
    n  = addr_chg;
    start_msg(32'h0000_0020, 3, 1'b0);
    wait_done(d0, "t2");
    chk("t2_reads", 32'(addr_chg - n), 32'd1);
    if (got.size() == 16) begin
      chk("t2_w0", got[0], 32'h6162_6380);
      chk("t2_w14", got[14], 32'h0000_0000);
      chk("t2_w15", got[15], 32'h0000_0018);
    end else fail_now("t2_count", $sformatf("words=%0d required=16", got.size()));

    // 56 bytes spills the length into a second block.
    run(32'h0000_0300, 56, 1'b0, 14, 8'hEE, "t3");
    chk("t3_count", 32'(got.size()), 32'd32);
    if (got.size() == 32) begin
      chk("t3_b0w14", got[14], 32'h8000_0000);
      chk("t3_b1w15", got[31], 32'h0000_01C0);
    end

    // 64 bytes with a randomly stalling consumer.
    run(32'h0000_0500, 64, 1'b1, 16, 8'hEE, "t4");
    chk("t4_count", 32'(got.size()), 32'd32);
    if (got.size() == 32) begin
      chk("t4_b1w0", got[16], 32'h8000_0000);
      chk("t4_b1w15", got[31], 32'h0000_0200);
    end

    // Word addresses wrap past 0xFFFF; upper message_addr bits are ignored.
    run(32'h0001_FFFE, 12, 1'b0, 3, 8'hEE, "wrap");

    // Mid-stream start is ignored, then reset abandons the stream.
    load_msg(32'h0000_0400, 20, 7, 8'hEE);
    build_expect(20);
    d0 = done_cnt;
    start_msg(32'h0000_0400, 20, 1'b0);
    n = 0;
    while (got.size() < 2 && n < 200) begin @(posedge clk); n++; end
    #1;
    message_addr = 32'h0000_0900;
    message_size = 32'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (got.size() < 5 && n < 200) begin @(posedge clk); n++; end
    if (got.size() < 5) fail_now("t5_progress", "stream did not reach word 5");
    #1;
    nreset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t5_rst_valid", {31'b0, w.w_valid}, 32'd0);
    chk("t5_rst_busy", {31'b0, busy}, 32'd0);
    chk("t5_no_done", 32'(done_cnt), 32'(d0));
    exp_q.delete();
    nreset = 1'b1;
    run(32'h0000_0040, 5, 1'b0, 2, 8'hEE, "t5_restart");
    chk("t5_restart_count", 32'(got.size()), 32'd16);

    repeat (3) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
